// File: rtl/lfsr_prbs_checker.sv
// ----------------------------------------------------------------------------
// lfsr_prbs_checker
//   Serial PRBS checker, the receive end of an LFSR pattern generator using
//   the same recurrence. It seeds its history from the incoming stream, hunts
//   for a run of correct predictions, and then free-runs its own prediction
//   while flagging and counting received bits that disagree with it.
//
//   Optional feature: define PRBS_CHK_BITCNT_EN to add the bit_cnt port and
//   counter (bits checked while LOCKED). Without it the port is absent.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active high
//   din_valid  in   1      din carries a bit this cycle
//   din        in   1      received serial bit
//   clear      in   1      synchronous clear of err_cnt (and bit_cnt)
//   locked     out  1      checker is in the LOCKED state
//   err_pulse  out  1      one-cycle flag: last valid bit mismatched while LOCKED
//   err_cnt    out  CNT_W  saturating count of LOCKED mismatches
//   bit_cnt    out  CNT_W  saturating count of LOCKED beats (PRBS_CHK_BITCNT_EN)
// ----------------------------------------------------------------------------
module lfsr_prbs_checker #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int               LOCK_CNT = 8,
  parameter int               WIN      = 64,
  parameter int               LOSS_THR = 4,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [CNT_W-1:0] bit_cnt
`endif
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int BEAT_W  = $clog2(WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THR - 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hist, hist_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [MATCH_W-1:0] match, match_nxt;
  logic [BEAT_W-1:0]  wbeat, wbeat_nxt;
  logic [WERR_W-1:0]  werr, werr_nxt;
  logic               pred;
  logic               mism;
  logic               err_inc;

  // Increment by inc, holding at all-ones once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Next-state, history and window bookkeeping
  always_comb begin
    pred      = ^(hist & TAPS);
    mism      = din ^ pred;
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    match_nxt = match;
    wbeat_nxt = wbeat;
    werr_nxt  = werr;
    err_inc   = 1'b0;

    if (din_valid) begin
      case (state)
        SEED: begin
          hist_nxt = {hist[WIDTH-2:0], din};
          if (fill == FILL_LAST) begin
            state_nxt = HUNT;
            fill_nxt  = '0;
            match_nxt = '0;
          end else begin
            fill_nxt = fill + FILL_W'(1);
          end
        end

        HUNT: begin
          hist_nxt = {hist[WIDTH-2:0], din};
          if (mism) begin
            match_nxt = '0;
          end else if (match == MATCH_LAST) begin
            state_nxt = LOCKED;
            match_nxt = '0;
            wbeat_nxt = '0;
            werr_nxt  = '0;
          end else begin
            match_nxt = match + MATCH_W'(1);
          end
        end

        LOCKED: begin
          // The prediction, not the received bit, feeds the history so an
          // isolated line error cannot poison later predictions.
          hist_nxt = {hist[WIDTH-2:0], pred};
          err_inc  = mism;
          if (mism && (werr == WERR_LAST)) begin
            state_nxt = SEED;
            fill_nxt  = '0;
            wbeat_nxt = '0;
            werr_nxt  = '0;
          end else if (wbeat == BEAT_LAST) begin
            // Window closes on this beat; any mismatch here belongs to the
            // closing window and is discarded with it.
            wbeat_nxt = '0;
            werr_nxt  = '0;
          end else begin
            wbeat_nxt = wbeat + BEAT_W'(1);
            werr_nxt  = werr + WERR_W'(mism);
          end
        end

        default: state_nxt = SEED;
      endcase
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      hist      <= '0;
      fill      <= '0;
      match     <= '0;
      wbeat     <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match     <= match_nxt;
      wbeat     <= wbeat_nxt;
      werr      <= werr_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_inc;
      err_cnt   <= clear ? CNT_W'(err_inc) : sat_inc(err_cnt, err_inc);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic bit_inc;
  assign bit_inc = din_valid && (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= clear ? CNT_W'(bit_inc) : sat_inc(bit_cnt, bit_inc);
    end
  end
`endif

endmodule
